dmem_port_arbiter: RTL and testbench

//  Shares the single-port, synchronous-read data RAM between two requesters.
//  M0 is the CPU load/store unit. M1 is the debug/loader port, used for

---
 rtl/dmem_port_arbiter.sv | 124 ++++++++++++
 tb/tb_dmem_port_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
//   Shares one single-port, synchronous-read data RAM between two requesters:
//   M0 (CPU load/store unit) and M1 (debug/loader port). At most one access
//   is granted per cycle. Read data is returned one cycle later to the
//   requester that issued the read.
//   Arbitration is chosen per cycle by rr_mode:
//     0 = fixed priority (M0 high) with a starvation guard for M1
//     1 = round-robin between the two masters
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   rr_mode             arbitration mode select (takes effect same cycle)
//   mN_req/we/be/addr/wdata   request from master N (held until mN_gnt)
//   mN_gnt              access accepted this cycle (combinational)
//   mN_rvalid/rdata     read return, one cycle after a granted read
//   ram_en/we/addr/wdata  RAM access port, muxed from the granted master
//   ram_rdata           RAM read data, valid one cycle after ram_en
module dmem_port_arbiter #(
    parameter int ADDR_WIDTH   = 12,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rr_mode,
    input  logic                    m0_req,
    input  logic                    m0_we,
    input  logic [DATA_WIDTH/8-1:0] m0_be,
    input  logic [ADDR_WIDTH-1:0]   m0_addr,
    input  logic [DATA_WIDTH-1:0]   m0_wdata,
    output logic                    m0_gnt,
    output logic                    m0_rvalid,
    output logic [DATA_WIDTH-1:0]   m0_rdata,
    input  logic                    m1_req,
    input  logic                    m1_we,
    input  logic [DATA_WIDTH/8-1:0] m1_be,
    input  logic [ADDR_WIDTH-1:0]   m1_addr,
    input  logic [DATA_WIDTH-1:0]   m1_wdata,
    output logic                    m1_gnt,
    output logic                    m1_rvalid,
    output logic [DATA_WIDTH-1:0]   m1_rdata,
    output logic                    ram_en,
    output logic [DATA_WIDTH/8-1:0] ram_we,
    output logic [ADDR_WIDTH-1:0]   ram_addr,
    output logic [DATA_WIDTH-1:0]   ram_wdata,
    input  logic [DATA_WIDTH-1:0]   ram_rdata
);

    localparam int              SW    = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0]   LIMIT = SW'(STARVE_LIMIT);

    logic [SW-1:0] starve_cnt;  // consecutive cycles M1 waited (fixed mode)
    logic          last_grant;  // 1 = M1 was granted most recently
    logic          rd_pend;     // a read was granted last cycle
    logic          rd_id;       // which master owns that read
    logic          rd_grant;    // this cycle's grant is a read

    // Grant decision. Everything is held off while rst is asserted so a
    // request held across reset is arbitrated only once rst drops.
    always_comb begin
        m0_gnt = 1'b0;
        m1_gnt = 1'b0;
        if (!rst) begin
            if (m0_req && m1_req) begin
                if (rr_mode)
                    m1_gnt = ~last_grant;
                else
                    m1_gnt = (starve_cnt == LIMIT);
                m0_gnt = ~m1_gnt;
            end else begin
                m0_gnt = m0_req;
                m1_gnt = m1_req;
            end
        end
    end

    // RAM port mux; idle and reset cycles drive zeros.
    always_comb begin
        ram_we    = '0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (m0_gnt) begin
            ram_we    = m0_we ? m0_be : '0;
            ram_addr  = m0_addr;
            ram_wdata = m0_wdata;
        end else if (m1_gnt) begin
            ram_we    = m1_we ? m1_be : '0;
            ram_addr  = m1_addr;
            ram_wdata = m1_wdata;
        end
    end

    assign ram_en   = m0_gnt | m1_gnt;
    assign rd_grant = (m0_gnt & ~m0_we) | (m1_gnt & ~m1_we);

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
            last_grant <= 1'b1;   // first round-robin conflict goes to M0
            rd_pend    <= 1'b0;
            rd_id      <= 1'b0;
        end else begin
            if (ram_en)
                last_grant <= m1_gnt;
            rd_pend <= rd_grant;
            if (rd_grant)
                rd_id <= m1_gnt;
            // Starvation counter only matters in fixed mode; it restarts
            // whenever M1 is served or gives up its request.
            if (rr_mode || !m1_req || m1_gnt)
                starve_cnt <= '0;
            else if (starve_cnt != LIMIT)
                starve_cnt <= starve_cnt + SW'(1);
        end
    end

    // rvalid is masked during reset so a read granted just before rst
    // rises never returns.
    assign m0_rvalid = rd_pend & ~rd_id & ~rst;
    assign m1_rvalid = rd_pend &  rd_id & ~rst;
    assign m0_rdata  = ram_rdata;
    assign m1_rdata  = ram_rdata;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: directed scenarios plus a
// randomized run checked against a rule-level arbitration/memory model.
module tb_dmem_port_arbiter;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int LIM = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rr_mode = 1'b0;
    logic          m0_req = 1'b0, m0_we = 1'b0;
    logic [BW-1:0] m0_be = '0;
    logic [AW-1:0] m0_addr = '0;
    logic [DW-1:0] m0_wdata = '0;
    logic          m0_gnt, m0_rvalid;
    logic [DW-1:0] m0_rdata;
    logic          m1_req = 1'b0, m1_we = 1'b0;
    logic [BW-1:0] m1_be = '0;
    logic [AW-1:0] m1_addr = '0;
    logic [DW-1:0] m1_wdata = '0;
    logic          m1_gnt, m1_rvalid;
    logic [DW-1:0] m1_rdata;
    logic          ram_en;
    logic [BW-1:0] ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata = '0;

    int n_cmp = 0;
    int n_fail = 0;

    dmem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .rst(rst), .rr_mode(rr_mode),
        .m0_req(m0_req), .m0_we(m0_we), .m0_be(m0_be), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_be(m1_be), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old,
                                            input logic [DW-1:0] wd,
                                            input logic [BW-1:0] be);
        logic [DW-1:0] r;
        r = old;
        for (int b = 0; b < BW; b++)
            if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    // Behavioural write-first synchronous RAM
    logic [DW-1:0] ram [0:(1<<AW)-1];
    initial for (int i = 0; i < (1 << AW); i++) ram[i] = '0;
    always @(posedge clk) begin
        if (ram_en) begin
            ram[ram_addr] <= merge(ram[ram_addr], ram_wdata, ram_we);
            ram_rdata     <= merge(ram[ram_addr], ram_wdata, ram_we);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        m0_req = 1'b0;
        m1_req = 1'b0;
        rr_mode = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 12'd5;
        m1_req = 1'b1; m1_we = 1'b1; m1_be = 4'hF; m1_addr = 12'd6; m1_wdata = 32'h1234;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_cmp++; if ({m0_gnt, m1_gnt, ram_en} !== 3'b000) begin n_fail++;
                $display("FAIL reset_gnt cyc%0d: got %b want 000", i, {m0_gnt, m1_gnt, ram_en}); end
            n_cmp++; if ({m0_rvalid, m1_rvalid} !== 2'b00) begin n_fail++;
                $display("FAIL reset_rvalid cyc%0d: got %b want 00", i, {m0_rvalid, m1_rvalid}); end
            n_cmp++; if (ram_we !== '0 || ram_addr !== '0 || ram_wdata !== '0) begin n_fail++;
                $display("FAIL reset_ramport cyc%0d: we=%h addr=%h wdata=%h want 0", i, ram_we, ram_addr, ram_wdata); end
            cyc();
        end
        m0_req = 1'b0;
        m1_req = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_m0_alone();
        do_reset();
        m0_req = 1'b1; m0_we = 1'b1; m0_be = 4'hF; m0_addr = 12'd0; m0_wdata = 32'd42;
        @(negedge clk);
        n_cmp++; if ({m0_gnt, m1_gnt, ram_en} !== 3'b101) begin n_fail++;
            $display("FAIL m0_wr_gnt: got %b want 101", {m0_gnt, m1_gnt, ram_en}); end
        n_cmp++; if (ram_we !== 4'hF || ram_addr !== 12'd0 || ram_wdata !== 32'd42) begin n_fail++;
            $display("FAIL m0_wr_port: we=%h addr=%h wdata=%h want F/0/42", ram_we, ram_addr, ram_wdata); end
        cyc();
        m0_we = 1'b0;
        @(negedge clk);
        n_cmp++; if (m0_gnt !== 1'b1 || ram_we !== 4'h0) begin n_fail++;
            $display("FAIL m0_rd_gnt: gnt=%b we=%h want 1/0", m0_gnt, ram_we); end
        cyc();
        m0_req = 1'b0;
        @(negedge clk);
        n_cmp++; if (m0_rvalid !== 1'b1 || m0_rdata !== 32'd42 || m1_rvalid !== 1'b0) begin n_fail++;
            $display("FAIL m0_rd_data: rv0=%b rdata=%0d rv1=%b want 1/42/0", m0_rvalid, m0_rdata, m1_rvalid); end
        cyc();
    endtask

    task automatic test_fixed_priority();
        do_reset();
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 12'd1;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 12'd2;
        for (int i = 0; i < 15; i++) begin
            logic exp1;
            exp1 = ((i % 5) == 4);
            @(negedge clk);
            n_cmp++; if ({m0_gnt, m1_gnt} !== {~exp1, exp1}) begin n_fail++;
                $display("FAIL fixed_prio cyc%0d: got %b want %b", i, {m0_gnt, m1_gnt}, {~exp1, exp1}); end
            cyc();
        end
        m0_req = 1'b0;
        m1_req = 1'b0;
    endtask

    task automatic test_round_robin();
        logic prev1;
        do_reset();
        rr_mode = 1'b1;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 12'd0;   // holds 42
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 12'd3;   // holds 0
        prev1 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            logic exp1;
            exp1 = ((i % 2) == 1);
            @(negedge clk);
            n_cmp++; if ({m0_gnt, m1_gnt} !== {~exp1, exp1}) begin n_fail++;
                $display("FAIL rr_gnt cyc%0d: got %b want %b", i, {m0_gnt, m1_gnt}, {~exp1, exp1}); end
            if (i > 0) begin
                n_cmp++; if ({m0_rvalid, m1_rvalid} !== {~prev1, prev1}) begin n_fail++;
                    $display("FAIL rr_rvalid cyc%0d: got %b want %b", i, {m0_rvalid, m1_rvalid}, {~prev1, prev1}); end
                n_cmp++; if (m0_rdata !== (prev1 ? 32'd0 : 32'd42)) begin n_fail++;
                    $display("FAIL rr_rdata cyc%0d: got %0d want %0d", i, m0_rdata, prev1 ? 0 : 42); end
            end
            prev1 = exp1;
            cyc();
        end
        m0_req = 1'b0;
        m1_req = 1'b0;
    endtask

    task automatic test_byte_enables();
        do_reset();
        m1_req = 1'b1; m1_we = 1'b1; m1_be = 4'hF; m1_addr = 12'd4; m1_wdata = 32'h0;
        cyc();
        m1_be = 4'b0011; m1_wdata = 32'hAABBCCDD;
        @(negedge clk);
        n_cmp++; if (m1_gnt !== 1'b1 || ram_we !== 4'b0011) begin n_fail++;
            $display("FAIL be_write: gnt=%b we=%b want 1/0011", m1_gnt, ram_we); end
        cyc();
        m1_we = 1'b0;
        cyc();
        m1_req = 1'b0;
        @(negedge clk);
        n_cmp++; if (m1_rvalid !== 1'b1 || m1_rdata !== 32'h0000CCDD || m0_rvalid !== 1'b0) begin n_fail++;
            $display("FAIL be_readback: rv1=%b rdata=%h rv0=%b want 1/0000ccdd/0", m1_rvalid, m1_rdata, m0_rvalid); end
        cyc();
    endtask

    task automatic test_reset_mid_read();
        do_reset();
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 12'd4;
        @(negedge clk);
        n_cmp++; if (m1_gnt !== 1'b1) begin n_fail++;
            $display("FAIL midrst_gnt: got %b want 1", m1_gnt); end
        cyc();
        rst = 1'b1;
        m1_req = 1'b0;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 12'd4;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_cmp++; if ({m0_gnt, m0_rvalid, m1_rvalid} !== 3'b000) begin n_fail++;
                $display("FAIL midrst_hold cyc%0d: gnt0/rv0/rv1=%b want 000", i, {m0_gnt, m0_rvalid, m1_rvalid}); end
            cyc();
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (m0_gnt !== 1'b1 || m1_rvalid !== 1'b0) begin n_fail++;
            $display("FAIL midrst_release: gnt0=%b rv1=%b want 1/0", m0_gnt, m1_rvalid); end
        cyc();
        m0_req = 1'b0;
        @(negedge clk);
        n_cmp++; if (m0_rvalid !== 1'b1 || m0_rdata !== 32'h0000CCDD) begin n_fail++;
            $display("FAIL midrst_read: rv0=%b rdata=%h want 1/0000ccdd", m0_rvalid, m0_rdata); end
        cyc();
    endtask

    // Random traffic on a private address window (16..23), checked against
    // the arbitration rules and a word-array memory model.
    task automatic test_random();
        logic [DW-1:0] ref_mem [0:7];
        bit  h0, h1, g0, g1, rv0, rv1, last1;
        int  denials;
        logic [DW-1:0] exp_rd;
        for (int i = 0; i < 8; i++) ref_mem[i] = '0;
        do_reset();
        h0 = 0; h1 = 0; rv0 = 0; rv1 = 0; last1 = 1; denials = 0; exp_rd = '0;
        for (int c = 0; c < 600; c++) begin
            if (!h0 && $urandom_range(0, 99) < 60) begin
                h0 = 1; m0_we = 1'($urandom_range(0, 1)); m0_be = 4'($urandom);
                m0_addr = 12'(16 + $urandom_range(0, 7)); m0_wdata = $urandom;
            end
            if (!h1 && $urandom_range(0, 99) < 60) begin
                h1 = 1; m1_we = 1'($urandom_range(0, 1)); m1_be = 4'($urandom);
                m1_addr = 12'(16 + $urandom_range(0, 7)); m1_wdata = $urandom;
            end
            m0_req = h0;
            m1_req = h1;
            if ($urandom_range(0, 15) == 0) rr_mode = ~rr_mode;
            // Expected winner from the arbitration rules
            if (h0 && h1) begin
                g1 = rr_mode ? !last1 : (denials == LIM);
                g0 = !g1;
            end else begin
                g0 = h0;
                g1 = h1;
            end
            @(negedge clk);
            n_cmp++; if ({m0_gnt, m1_gnt} !== {g0, g1}) begin n_fail++;
                $display("FAIL rnd_gnt cyc%0d: got %b want %b", c, {m0_gnt, m1_gnt}, {g0, g1}); end
            n_cmp++; if ({m0_rvalid, m1_rvalid} !== {rv0, rv1}) begin n_fail++;
                $display("FAIL rnd_rvalid cyc%0d: got %b want %b", c, {m0_rvalid, m1_rvalid}, {rv0, rv1}); end
            if (rv0 || rv1) begin
                n_cmp++; if ((rv0 ? m0_rdata : m1_rdata) !== exp_rd) begin n_fail++;
                    $display("FAIL rnd_rdata cyc%0d: got %h want %h", c, rv0 ? m0_rdata : m1_rdata, exp_rd); end
            end
            if (g0 || g1) begin
                n_cmp++; if (ram_en !== 1'b1 || ram_addr !== (g0 ? m0_addr : m1_addr)) begin n_fail++;
                    $display("FAIL rnd_port cyc%0d: en=%b addr=%h", c, ram_en, ram_addr); end
            end
            // Advance the model across the clock edge
            if (g0 || g1) last1 = g1;
            if (rr_mode || !h1 || g1) denials = 0;
            else if (denials < LIM) denials++;
            rv0 = g0 && !m0_we;
            rv1 = g1 && !m1_we;
            if (g0) begin
                if (m0_we) ref_mem[m0_addr - 16] = merge(ref_mem[m0_addr - 16], m0_wdata, m0_be);
                else exp_rd = ref_mem[m0_addr - 16];
                h0 = 0;
            end
            if (g1) begin
                if (m1_we) ref_mem[m1_addr - 16] = merge(ref_mem[m1_addr - 16], m1_wdata, m1_be);
                else exp_rd = ref_mem[m1_addr - 16];
                h1 = 0;
            end
            cyc();
        end
        m0_req = 1'b0;
        m1_req = 1'b0;
    endtask

    initial begin
        #20000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc();
        test_reset();
        test_m0_alone();
        test_fixed_priority();
        test_round_robin();
        test_byte_enables();
        test_reset_mid_read();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
